// File: rtl/sha256_pkg.sv
// SHA-256/224 shared constants, types and round helper functions.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV_256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV_224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t Sigma0(word_t a);
    return rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
  endfunction

  function automatic word_t Sigma1(word_t e);
    return rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
  endfunction

  function automatic word_t Ch(word_t e, word_t f, word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t Maj(word_t a, word_t b, word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; state index 0 is 'a', index 7 is 'h'.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] st_in,
  input  word_t            w_in,
  input  word_t            k_in,
  output logic [7:0][31:0] st_out
);

  word_t t1, t2;

  assign t1 = st_in[7] + Sigma1(st_in[4]) + Ch(st_in[4], st_in[5], st_in[6]) + k_in + w_in;
  assign t2 = Sigma0(st_in[0]) + Maj(st_in[0], st_in[1], st_in[2]);

  assign st_out[0] = t1 + t2;
  assign st_out[1] = st_in[0];
  assign st_out[2] = st_in[1];
  assign st_out[3] = st_in[2];
  assign st_out[4] = st_in[3] + t1;
  assign st_out[5] = st_in[4];
  assign st_out[6] = st_in[5];
  assign st_out[7] = st_in[6];

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256/224 compression: one round per accepted schedule word,
// then a feed-forward add and a serial digest drain.
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_in,
  input  logic                  first_blk_in,
  input  logic                  w_valid_in,
  input  logic [DATA_WIDTH-1:0] w_data_in,
  output logic                  w_ready_out,
  output logic                  h_valid_out,
  output logic [DATA_WIDTH-1:0] h_data_out,
  output logic                  h_last_out,
  input  logic                  h_ready_in,
  output logic                  busy_out
);

  if (DATA_WIDTH != 32 || NUM_ROUNDS != 64) begin : g_bad_param
    $error("sha256_compress_core: only DATA_WIDTH=32 and NUM_ROUNDS=64 are supported");
  end

  localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS - 1);

  state_t           state;
  logic [5:0]       round_cnt;
  logic [2:0]       out_idx;
  logic             mode_q;
  logic [7:0][31:0] wv_q;
  logic [7:0][31:0] h_q;
  logic [7:0][31:0] iv_sel;
  logic [7:0][31:0] rnd_in;
  logic [7:0][31:0] rnd_out;
  word_t            k_sel;
  logic [2:0]       last_idx;
  logic             accept;

  assign w_ready_out = (state == ST_IDLE) || (state == ST_ROUND);
  assign accept      = w_valid_in && w_ready_out;
  assign last_idx    = mode_q ? 3'd6 : 3'd7;
  assign h_valid_out = (state == ST_OUT);
  assign h_data_out  = h_valid_out ? h_q[out_idx] : '0;
  assign h_last_out  = h_valid_out && (out_idx == last_idx);
  assign busy_out    = (state != ST_IDLE);

  // Round 0 is computed straight from IV or chained H, so IDLE acceptance
  // already lands the first round in the working registers.
  always_comb begin
    for (int i = 0; i < 8; i++) iv_sel[i] = mode_in ? IV_224[i] : IV_256[i];
    rnd_in = wv_q;
    k_sel  = K[round_cnt];
    if (state == ST_IDLE) begin
      rnd_in = first_blk_in ? iv_sel : h_q;
      k_sel  = K[0];
    end
  end

  sha256_round u_round (
    .st_in  (rnd_in),
    .w_in   (w_data_in),
    .k_in   (k_sel),
    .st_out (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
      out_idx   <= '0;
      mode_q    <= 1'b0;
      wv_q      <= '0;
      h_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          wv_q      <= rnd_out;
          round_cnt <= 6'd1;
          state     <= ST_ROUND;
          // H holds the feed-forward base; on a new message that is the IV
          if (first_blk_in) begin
            h_q    <= iv_sel;
            mode_q <= mode_in;
          end
        end
        ST_ROUND: if (accept) begin
          wv_q <= rnd_out;
          if (round_cnt == LAST_RND) begin
            round_cnt <= '0;
            state     <= ST_UPDATE;
          end else begin
            round_cnt <= round_cnt + 6'd1;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
          out_idx <= '0;
          state   <= ST_OUT;
        end
        ST_OUT: if (h_ready_in) begin
          if (out_idx == last_idx) begin
            out_idx <= '0;
            state   <= ST_IDLE;
          end else begin
            out_idx <= out_idx + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
